// File: rtl/rsr_pkg.sv
// Shared types and constants for the iterative rotate-right unit.
// Contents: FSM state enum, default operand width, amount-field width.
package rsr_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned AMT_BITS      = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage : rsr_pkg

// File: rtl/rsr_step.sv
// Single-step combinational right rotator: rotates by 1, or by 4 when step4 is set.
// Ports:
//   data    - value to rotate
//   step4   - 1: rotate right by 4, 0: rotate right by 1
//   rotated - rotated value
module rsr_step #(
    parameter int unsigned WIDTH = rsr_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic             step4,
    output logic [WIDTH-1:0] rotated
);

    always_comb begin
        rotated = {data[0], data[WIDTH-1:1]};
        if (step4) begin
            rotated = {data[3:0], data[WIDTH-1:4]};
        end
    end

endmodule : rsr_step

// File: rtl/rsr16_iter.sv
// Iterative rotate-right unit: accepts an operand and amount over valid/ready,
// rotates one position per clock (or four when RSR_STEP4_EN is defined) and
// holds the result on a valid/ready output until consumed.
// Optional build macro: RSR_STEP4_EN - coarse 4-bit steps while cnt >= 4.
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  - operation handshake (in_ready high only in IDLE)
//   inp, shift_value    - operand and rotate amount (low $clog2(WIDTH) bits used)
//   out_valid, out_ready- result handshake (out_valid high only in DONE)
//   out                 - registered rotated result
//   busy                - high whenever the unit is not IDLE
module rsr16_iter #(
    parameter int unsigned WIDTH = rsr_pkg::DEFAULT_WIDTH,
    parameter int unsigned AMT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inp,
    input  logic [AMT_W-1:0] shift_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    import rsr_pkg::*;

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] cnt;

    logic             step4_c;
    logic [CNT_W-1:0] step_size_c;
    logic [CNT_W-1:0] cnt_next_c;
    logic [WIDTH-1:0] step_data_c;
    logic [CNT_W-1:0] amt_c;

    // Amounts wrap modulo WIDTH simply by dropping the upper bits.
    assign amt_c = shift_value[CNT_W-1:0];

    if (AMT_W > CNT_W) begin : g_amt_hi
        logic unused_amt_hi;
        assign unused_amt_hi = ^shift_value[AMT_W-1:CNT_W];
    end

`ifdef RSR_STEP4_EN
    assign step4_c = (cnt >= CNT_W'(4));
`else
    assign step4_c = 1'b0;
`endif

    assign step_size_c = step4_c ? CNT_W'(4) : CNT_W'(1);
    assign cnt_next_c  = cnt - step_size_c;

    rsr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data    (data_r),
        .step4   (step4_c),
        .rotated (step_data_c)
    );

    // Control FSM with datapath registers; out only loads on DONE entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            data_r <= '0;
            cnt    <= '0;
            out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_r <= inp;
                        cnt    <= amt_c;
                        if (amt_c == '0) begin
                            state <= DONE;
                            out   <= inp;
                        end else begin
                            state <= ROTATE;
                        end
                    end
                end
                ROTATE: begin
                    data_r <= step_data_c;
                    cnt    <= cnt_next_c;
                    if (cnt_next_c == '0) begin
                        state <= DONE;
                        out   <= step_data_c;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags are pure decodes of the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule : rsr16_iter

// File: tb/tb_rsr16_iter.sv
// Scoreboard bench for rsr16_iter: driver pushes expected result/latency from
// an arithmetic rotate model, monitor pops and compares on each new result.
module tb_rsr16_iter;

    typedef struct {
        logic [15:0] val;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] inp = 16'h0;
    logic [15:0] shift_value = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   hold_bp = 1'b1;
    exp_t q[$];

    logic [15:0] dir_d [0:6] = '{16'h000B, 16'h8001, 16'hFFFF, 16'h1234, 16'h1234, 16'h000B, 16'h000B};
    logic [15:0] dir_a [0:6] = '{16'd4,    16'd1,    16'd8,    16'd20,   16'd16,   16'd7,    16'd0};

    rsr16_iter dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .inp         (inp),
        .shift_value (shift_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: rotate right by (amt mod 16) using a doubled word.
    function automatic logic [15:0] model_ror(input logic [15:0] x, input logic [15:0] amt);
        int          k;
        logic [31:0] d;
        k = int'(amt) % 16;
        d = {x, x} >> k;
        return d[15:0];
    endfunction

    function automatic int model_lat(input logic [15:0] amt);
        int k;
        k = int'(amt) % 16;
`ifdef RSR_STEP4_EN
        return 1 + (k / 4) + (k % 4);
`else
        return 1 + k;
`endif
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Issue one operation; returns at the negedge after acceptance.
    task automatic do_op(input logic [15:0] d, input logic [15:0] a);
        int n;
        n = 0;
        @(negedge clk);
        in_valid    = 1'b1;
        inp         = d;
        shift_value = a;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
            in_valid = 1'b0;
            return;
        end
        q.push_back('{model_ror(d, a), model_lat(a), cyc});
        @(negedge clk);
        in_valid    = 1'b0;
        inp         = 16'($urandom);
        shift_value = 16'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !in_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", q.size());
            q.delete();
        end
    endtask

    // Random consumer backpressure unless the main thread owns out_ready.
    initial begin
        forever begin
            @(negedge clk);
            if (!hold_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare value and latency on each fresh out_valid.
    initial begin : monitor
        logic prev_ov;
        exp_t e;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && out_valid && !prev_ov) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=no_result", out);
                end else begin
                    e = q.pop_front();
                    check("result", int'(out), int'(e.val));
                    check("latency", cyc - e.acc, e.lat);
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin : main
        logic [15:0] held;
        int          n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out", int'(out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);

        // Directed cases with random consumer backpressure
        hold_bp = 1'b0;
        for (int i = 0; i < 7; i++) begin
            do_op(dir_d[i], dir_a[i]);
            wait_drain();
        end

        // Backpressure: DONE held, outputs stable, in_valid ignored
        hold_bp   = 1'b1;
        out_ready = 1'b0;
        do_op(16'h000B, 16'd4);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach_done", int'(out_valid), 1);
        held = out;
        for (int i = 0; i < 3; i++) begin
            in_valid    = 1'b1;
            inp         = 16'($urandom);
            shift_value = 16'($urandom);
            @(negedge clk);
            check("bp_out_stable", int'(out), int'(held));
            check("bp_valid_held", int'(out_valid), 1);
            check("bp_busy_held", int'(busy), 1);
            check("bp_in_ready_low", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_busy", int'(busy), 0);
        check("bp_out_kept", int'(out), int'(held));

        // Asynchronous reset during a long rotate
        hold_bp = 1'b0;
        do_op(16'hA5C3, 16'd12);
        @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_out", int'(out), 0);
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_busy", int'(busy), 0);
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_in_ready", int'(in_ready), 1);
        do_op(16'h1234, 16'd20);
        wait_drain();

        // Randomized traffic, including back-to-back issue
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(16'($urandom), 16'($urandom));
        end
        wait_drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rsr16_iter
